// File: rtl/frame_buf_ctrl.sv
// Double-buffered RGB frame store with a PWM phase counter. The host fills the back
// bank; the scan side reads the front bank. Banks swap only at the end of a full PWM cycle.
module frame_buf_ctrl #(
  parameter int MATRIX_NUM  = 4,
  parameter int MATRIX_SIZE = 8,
  parameter int ROW_WIDTH   = 2*MATRIX_SIZE,
  parameter int PWM_DEPTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [1:0]           wr_matrix_i,
  input  logic [2:0]           wr_row_i,
  input  logic [3:0]           wr_col_i,
  input  logic [23:0]          wr_rgb_i,
  input  logic                 commit_i,
  output logic                 commit_pending_o,
  output logic                 wr_err_o,
  input  logic                 frame_end_i,
  output logic [PWM_DEPTH-1:0] pwm_cnt_o,
  input  logic                 rd_req_i,
  input  logic [1:0]           rd_matrix_i,
  input  logic [2:0]           rd_row_i,
  input  logic [3:0]           rd_col_i,
  output logic [23:0]          rd_rgb_o,
  output logic                 rd_valid_o,
  output logic                 disp_bank_o
);
  localparam int DEPTH = MATRIX_NUM*MATRIX_SIZE*ROW_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {OPEN, PEND, SWAP} state_t;
  state_t state_q, state_d;

  logic [PWM_DEPTH-1:0] pwm_q;
  logic [23:0]          bank0 [DEPTH];
  logic [23:0]          bank1 [DEPTH];
  logic [AW-1:0]        wr_addr, rd_addr;
  logic                 wr_in_range, rd_in_range, wr_acc, pwm_max;

  assign wr_in_range = (32'(wr_row_i) < MATRIX_SIZE) && (32'(wr_col_i) < ROW_WIDTH);
  assign rd_in_range = (32'(rd_row_i) < MATRIX_SIZE) && (32'(rd_col_i) < ROW_WIDTH);
  assign wr_addr = AW'(wr_matrix_i)*AW'(MATRIX_SIZE*ROW_WIDTH) + AW'(wr_row_i)*AW'(ROW_WIDTH) + AW'(wr_col_i);
  assign rd_addr = AW'(rd_matrix_i)*AW'(MATRIX_SIZE*ROW_WIDTH) + AW'(rd_row_i)*AW'(ROW_WIDTH) + AW'(rd_col_i);

  assign wr_ready_o       = (state_q == OPEN);
  assign commit_pending_o = (state_q == PEND);
  assign wr_acc           = wr_valid_i && wr_ready_o;
  assign pwm_max          = &pwm_q;
  assign pwm_cnt_o        = pwm_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OPEN:    if (commit_i) state_d = PEND;
      PEND:    if (frame_end_i && pwm_max) state_d = SWAP;
      SWAP:    state_d = OPEN;
      default: state_d = OPEN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= OPEN;
      pwm_q       <= '0;
      disp_bank_o <= 1'b0;
      wr_err_o    <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_rgb_o    <= '0;
    end else begin
      state_q <= state_d;
      // The triggering frame_end already wrapped pwm to 0; any pulse during SWAP is dropped.
      if (state_q == SWAP) begin
        disp_bank_o <= ~disp_bank_o;
        pwm_q       <= '0;
      end else if (frame_end_i) begin
        pwm_q <= pwm_q + PWM_DEPTH'(1);
      end
      if (wr_acc && !wr_in_range) wr_err_o <= 1'b1;
      rd_valid_o <= rd_req_i;
      if (rd_req_i)
        rd_rgb_o <= !rd_in_range ? 24'h0 : (disp_bank_o ? bank1[rd_addr] : bank0[rd_addr]);
    end
  end

  // Pixel storage is never reset; writes always land in the back bank.
  always_ff @(posedge clk_i) begin
    if (wr_acc && wr_in_range) begin
      if (disp_bank_o) bank0[wr_addr] <= wr_rgb_i;
      else             bank1[wr_addr] <= wr_rgb_i;
    end
  end
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Bench for frame_buf_ctrl: default instance checked against a bank/array model,
// plus a 6-row instance so out-of-range addresses are reachable through the 3/4-bit ports.
module tb_frame_buf_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        wr_valid_i, commit_i, frame_end_i, rd_req_i;
  logic [1:0]  wr_matrix_i, rd_matrix_i;
  logic [2:0]  wr_row_i, rd_row_i;
  logic [3:0]  wr_col_i, rd_col_i;
  logic [23:0] wr_rgb_i;
  logic        wr_ready_o, commit_pending_o, wr_err_o, rd_valid_o, disp_bank_o;
  logic [7:0]  pwm_cnt_o;
  logic [23:0] rd_rgb_o;
  logic        s_ready, s_pend, s_err, s_rdv, s_disp;
  logic [7:0]  s_pwm;
  logic [23:0] s_rgb;

  frame_buf_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_matrix_i(wr_matrix_i), .wr_row_i(wr_row_i), .wr_col_i(wr_col_i), .wr_rgb_i(wr_rgb_i),
    .commit_i(commit_i), .commit_pending_o(commit_pending_o), .wr_err_o(wr_err_o),
    .frame_end_i(frame_end_i), .pwm_cnt_o(pwm_cnt_o), .rd_req_i(rd_req_i),
    .rd_matrix_i(rd_matrix_i), .rd_row_i(rd_row_i), .rd_col_i(rd_col_i),
    .rd_rgb_o(rd_rgb_o), .rd_valid_o(rd_valid_o), .disp_bank_o(disp_bank_o));

  frame_buf_ctrl #(.MATRIX_SIZE(6)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(s_ready),
    .wr_matrix_i(wr_matrix_i), .wr_row_i(wr_row_i), .wr_col_i(wr_col_i), .wr_rgb_i(wr_rgb_i),
    .commit_i(commit_i), .commit_pending_o(s_pend), .wr_err_o(s_err),
    .frame_end_i(frame_end_i), .pwm_cnt_o(s_pwm), .rd_req_i(rd_req_i),
    .rd_matrix_i(rd_matrix_i), .rd_row_i(rd_row_i), .rd_col_i(rd_col_i),
    .rd_rgb_o(s_rgb), .rd_valid_o(s_rdv), .disp_bank_o(s_disp));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two pixel arrays, front index, phase, pending flag and swap-in-progress flag.
  logic [23:0] mb [2][512];
  bit          mk [2][512];
  int          mdisp = 0, mpwm = 0;
  bit          mpend = 0, mswap = 0;
  logic [23:0] mrd = '0;
  bit          mrd_k = 1;

  function automatic int lin(input int m, input int r, input int c);
    return m*128 + r*16 + c;
  endfunction

  task automatic model_reset();
    mdisp = 0; mpwm = 0; mpend = 0; mswap = 0; mrd = '0; mrd_k = 1;
  endtask

  task automatic idle();
    wr_valid_i = 0; commit_i = 0; frame_end_i = 0; rd_req_i = 0;
    wr_matrix_i = 0; wr_row_i = 0; wr_col_i = 0; wr_rgb_i = 0;
    rd_matrix_i = 0; rd_row_i = 0; rd_col_i = 0;
  endtask

  task automatic step();
    bit p0, nk;
    logic [23:0] nd;
    int a;
    nk = 0; nd = '0;
    if (rd_req_i) begin
      a = lin(rd_matrix_i, rd_row_i, rd_col_i);
      nd = mb[mdisp][a]; nk = mk[mdisp][a];
    end
    if (mswap) begin
      mdisp = 1 - mdisp; mswap = 0;
    end else begin
      p0 = mpend;
      if (!p0 && wr_valid_i) begin
        a = lin(wr_matrix_i, wr_row_i, wr_col_i);
        mb[1-mdisp][a] = wr_rgb_i; mk[1-mdisp][a] = 1;
      end
      if (!p0 && commit_i) mpend = 1;
      if (frame_end_i) begin
        if (p0 && mpwm == 255) begin mswap = 1; mpend = 0; end
        mpwm = (mpwm + 1) % 256;
      end
    end
    @(posedge clk_i); #1;
    chk("wr_ready", wr_ready_o, !mpend && !mswap);
    chk("commit_pending", commit_pending_o, mpend);
    chk("pwm_cnt", pwm_cnt_o, mpwm);
    chk("disp_bank", disp_bank_o, mdisp);
    chk("rd_valid", rd_valid_o, rd_req_i);
    chk("wr_err", wr_err_o, 0);
    if (rd_req_i) begin mrd = nd; mrd_k = nk; end
    if (mrd_k) chk("rd_rgb", rd_rgb_o, mrd);
  endtask

  task automatic pulse_to(input int target);
    int n;
    n = 0;
    while (mpwm != target && n < 600) begin
      frame_end_i = 1; step(); frame_end_i = 0; step(); n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL pulse_to: pwm %0d target %0d not reached", mpwm, target);
    end
  endtask

  typedef struct {
    bit wv; int m, r, c; logic [23:0] rgb; bit cm, fe;
    int exp_pwm; bit exp_rdy, exp_pend, exp_serr;
  } vec_t;
  vec_t vt [7];

  initial begin
    bit prev_fe;
    int n;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 512; i++) mk[b][i] = 0;
    idle();
    #12;
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_pend", commit_pending_o, 0);
    chk("rst_pwm", pwm_cnt_o, 0);
    chk("rst_disp", disp_bank_o, 0);
    chk("rst_err", wr_err_o, 0);
    chk("rst_rdv", rd_valid_o, 0);
    chk("rst_rgb", rd_rgb_o, 0);
    @(negedge clk_i); rst_i = 1;

    vt[0] = '{1, 1, 2, 5,  24'h123456, 0, 0, 0, 1, 0, 0};
    vt[1] = '{1, 1, 1, 0,  24'h0A0B0C, 0, 1, 1, 1, 0, 0};
    vt[2] = '{1, 0, 7, 0,  24'hDEAD00, 0, 0, 1, 1, 0, 1};
    vt[3] = '{0, 0, 0, 0,  24'h000000, 0, 1, 2, 1, 0, 1};
    vt[4] = '{1, 2, 3, 13, 24'h111111, 0, 0, 2, 1, 0, 1};
    vt[5] = '{1, 0, 0, 0,  24'hABCDEF, 1, 1, 3, 0, 1, 1};
    vt[6] = '{1, 1, 2, 5,  24'h999999, 0, 0, 3, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      wr_valid_i = vt[i].wv; wr_matrix_i = 2'(vt[i].m); wr_row_i = 3'(vt[i].r);
      wr_col_i = 4'(vt[i].c); wr_rgb_i = vt[i].rgb; commit_i = vt[i].cm; frame_end_i = vt[i].fe;
      step();
      chk($sformatf("vec%0d_pwm", i), pwm_cnt_o, vt[i].exp_pwm);
      chk($sformatf("vec%0d_ready", i), wr_ready_o, vt[i].exp_rdy);
      chk($sformatf("vec%0d_pend", i), commit_pending_o, vt[i].exp_pend);
      chk($sformatf("vec%0d_small_err", i), s_err, vt[i].exp_serr);
      chk($sformatf("vec%0d_small_ready", i), s_ready, vt[i].exp_rdy);
    end

    // First swap: pending until the pulse seen at max phase.
    idle();
    pulse_to(255);
    chk("r1_pend_at_max", commit_pending_o, 1);
    frame_end_i = 1; step(); frame_end_i = 0;
    chk("r1_swap_pwm", pwm_cnt_o, 0);
    chk("r1_swap_disp_pre", disp_bank_o, 0);
    chk("r1_swap_ready", wr_ready_o, 0);
    rd_req_i = 1; rd_matrix_i = 1; rd_row_i = 2; rd_col_i = 5;
    step();
    chk("r1_disp_post", disp_bank_o, 1);
    step();
    chk("r1_rd_pixel", rd_rgb_o, 24'h123456);
    chk("r1_rd_valid", rd_valid_o, 1);
    rd_row_i = 1; rd_col_i = 0;
    step();
    chk("small_alias_intact", s_rgb, 24'h0A0B0C);
    rd_matrix_i = 0; rd_row_i = 7; rd_col_i = 0;
    step();
    chk("small_oor_rd_rgb", s_rgb, 24'h0);
    chk("small_oor_rd_valid", s_rdv, 1);
    rd_req_i = 0;
    step();
    chk("small_rd_hold", s_rgb, 24'h0);
    chk("small_rdv_pulse", s_rdv, 0);

    // Second swap: commit at phase 10, PEND writes refused, read across the swap edge.
    wr_valid_i = 1; wr_matrix_i = 1; wr_row_i = 2; wr_col_i = 5; wr_rgb_i = 24'h654321;
    step(); idle();
    pulse_to(10);
    commit_i = 1; step(); commit_i = 0;
    chk("r2_pend", commit_pending_o, 1);
    chk("r2_pwm", pwm_cnt_o, 10);
    wr_valid_i = 1; wr_matrix_i = 1; wr_row_i = 2; wr_col_i = 5; wr_rgb_i = 24'h777777;
    rd_req_i = 1; rd_matrix_i = 1; rd_row_i = 2; rd_col_i = 5;
    pulse_to(255);
    chk("r2_front_unchanged", rd_rgb_o, 24'h123456);
    chk("r2_ready_pend", wr_ready_o, 0);
    frame_end_i = 1; wr_valid_i = 0; step(); frame_end_i = 0;
    step();
    chk("r2_rd_swap_edge", rd_rgb_o, 24'h123456);
    step();
    chk("r2_rd_after_swap", rd_rgb_o, 24'h654321);
    idle();

    // Randomized traffic against the model.
    prev_fe = 0;
    for (int i = 0; i < 3000; i++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_matrix_i = 2'($urandom); wr_row_i = 3'($urandom); wr_col_i = 4'($urandom);
      wr_rgb_i = 24'($urandom);
      commit_i = ($urandom_range(0, 39) == 0);
      frame_end_i = prev_fe ? 1'b0 : 1'($urandom_range(0, 1));
      prev_fe = frame_end_i;
      rd_req_i = 1'($urandom_range(0, 1));
      rd_matrix_i = 2'($urandom); rd_row_i = 3'($urandom); rd_col_i = 4'($urandom);
      step();
    end
    idle();

    // Drain to OPEN, then park in PEND at phase 100 and reset asynchronously.
    n = 0;
    while ((mpend || mswap) && n < 600) begin
      frame_end_i = 1; step(); frame_end_i = 0; step(); n++;
    end
    if (n >= 600) begin checks++; errors++; $display("FAIL drain: still pending"); end
    pulse_to(50);
    commit_i = 1; step(); commit_i = 0;
    pulse_to(100);
    chk("pre_rst_pend", commit_pending_o, 1);
    chk("pre_rst_pwm", pwm_cnt_o, 100);
    #2 rst_i = 0;
    #1;
    chk("arst_ready", wr_ready_o, 1);
    chk("arst_pend", commit_pending_o, 0);
    chk("arst_pwm", pwm_cnt_o, 0);
    chk("arst_disp", disp_bank_o, 0);
    chk("arst_rgb", rd_rgb_o, 0);
    chk("arst_small_err", s_err, 0);
    model_reset();
    @(negedge clk_i); rst_i = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
